// File: rtl/galois_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : galois_lfsr_checker
// Purpose  : Self-seeding PRBS checker for a galois_lfsr word stream; locks,
//            flywheels, counts mismatches and grades each done-framed period.
// Revision : 1.0 - initial release
// ============================================================================
module galois_lfsr_checker #(
  parameter int                   BIT_WIDTH  = 8,
  parameter logic [BIT_WIDTH-1:0] TAPS       = 8'hB8,
  parameter int                   LOCK_CNT   = 4,
  parameter int                   UNLOCK_CNT = 4,
  parameter int                   ERR_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_vld,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_done,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [BIT_WIDTH:0]   word_cnt,
  output logic                 seq_done,
  output logic                 seq_pass
);

  localparam logic [1:0] c_HUNT   = 2'd0;
  localparam logic [1:0] c_VERIFY = 2'd1;
  localparam logic [1:0] c_LOCK   = 2'd2;

  localparam logic [3:0]           c_LOCK_CNT   = 4'(LOCK_CNT);
  localparam logic [3:0]           c_UNLOCK_CNT = 4'(UNLOCK_CNT);
  localparam logic [BIT_WIDTH:0]   c_WORD_MAX   = {(BIT_WIDTH+1){1'b1}};
  localparam logic [BIT_WIDTH:0]   c_PERIOD     = {1'b0, {BIT_WIDTH{1'b1}}};
  localparam logic [ERR_W-1:0]     c_ERR_MAX    = {ERR_W{1'b1}};

  function automatic logic [BIT_WIDTH-1:0] lfsr_next(input logic [BIT_WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : '0);
  endfunction

  logic [1:0]           r_state;
  logic [BIT_WIDTH-1:0] r_pred;
  logic [3:0]           r_match_run;
  logic [3:0]           r_miss_run;
  logic                 r_seq_err;

  logic [1:0]           w_state_n;
  logic [BIT_WIDTH-1:0] w_pred_n;
  logic [3:0]           w_match_n;
  logic [3:0]           w_miss_n;
  logic                 w_err;
  logic                 w_seq_err_n;
  logic [BIT_WIDTH:0]   w_word_n;

  always_comb begin
    w_state_n = r_state;
    w_pred_n  = r_pred;
    w_match_n = r_match_run;
    w_miss_n  = r_miss_run;
    w_err     = 1'b0;
    if (in_vld) begin
      case (r_state)
        c_HUNT: begin
          // An all-zero word is the LFSR lockup state and cannot seed.
          if (in_data != '0) begin
            w_pred_n  = lfsr_next(in_data);
            w_match_n = '0;
            w_state_n = c_VERIFY;
          end
        end
        c_VERIFY: begin
          if (in_data == r_pred) begin
            w_pred_n  = lfsr_next(r_pred);
            w_match_n = r_match_run + 4'd1;
            if (w_match_n == c_LOCK_CNT) begin
              w_state_n = c_LOCK;
              w_miss_n  = '0;
            end
          end else begin
            w_match_n = '0;
            w_pred_n  = lfsr_next(in_data);
            if (in_data == '0) w_state_n = c_HUNT;
          end
        end
        c_LOCK: begin
          // Flywheel: prediction advances whether or not the word matched.
          w_pred_n = lfsr_next(r_pred);
          if (in_data == r_pred) begin
            w_miss_n = '0;
          end else begin
            w_err    = 1'b1;
            w_miss_n = r_miss_run + 4'd1;
            if (w_miss_n == c_UNLOCK_CNT) begin
              w_state_n = c_HUNT;
              w_miss_n  = '0;
              w_match_n = '0;
            end
          end
        end
        default: w_state_n = c_HUNT;
      endcase
    end
    w_seq_err_n = r_seq_err | w_err;
    w_word_n    = (in_vld && word_cnt != c_WORD_MAX) ? word_cnt + 1'b1 : word_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_HUNT;
      r_pred      <= '0;
      r_match_run <= '0;
      r_miss_run  <= '0;
      r_seq_err   <= 1'b0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_cnt     <= '0;
      word_cnt    <= '0;
      seq_done    <= 1'b0;
      seq_pass    <= 1'b0;
    end else if (clr) begin
      r_state     <= c_HUNT;
      r_pred      <= '0;
      r_match_run <= '0;
      r_miss_run  <= '0;
      r_seq_err   <= 1'b0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_cnt     <= '0;
      word_cnt    <= '0;
      seq_done    <= 1'b0;
      seq_pass    <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pred      <= w_pred_n;
      r_match_run <= w_match_n;
      r_miss_run  <= w_miss_n;
      locked      <= (w_state_n == c_LOCK);
      err_pulse   <= w_err;
      if (w_err && err_cnt != c_ERR_MAX) err_cnt <= err_cnt + 1'b1;
      seq_done    <= in_done;
      // A word arriving with in_done closes the current sequence.
      if (in_done) begin
        seq_pass  <= (w_state_n == c_LOCK) && !w_seq_err_n && (w_word_n == c_PERIOD);
        word_cnt  <= '0;
        r_seq_err <= 1'b0;
      end else begin
        word_cnt  <= w_word_n;
        r_seq_err <= w_seq_err_n;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_galois_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_galois_lfsr_checker
// Purpose  : Randomized bench for galois_lfsr_checker against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_galois_lfsr_checker;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 4;

  logic clk = 1'b0;
  logic rst, clr, in_vld, in_done;
  logic [7:0] in_data;
  logic locked, err_pulse, seq_done, seq_pass;
  logic [15:0] err_cnt;
  logic [8:0] word_cnt;
  logic locked2, err_pulse2, seq_done2, seq_pass2;
  logic [1:0] err_cnt2;
  logic [8:0] word_cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  int gen;

  // Behavioural reference: mode 0 = hunting, 1 = verifying, 2 = locked
  int m_mode, m_pred, m_run, m_miss, m_errs, m_words;
  bit m_seqerr, m_errp, m_sdone, m_spass;

  galois_lfsr_checker #(.BIT_WIDTH(8), .TAPS(8'hB8), .LOCK_CNT(LOCK_CNT),
                        .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_data(in_data),
    .in_done(in_done), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .word_cnt(word_cnt), .seq_done(seq_done), .seq_pass(seq_pass));

  galois_lfsr_checker #(.BIT_WIDTH(8), .TAPS(8'hB8), .LOCK_CNT(LOCK_CNT),
                        .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_data(in_data),
    .in_done(in_done), .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2),
    .word_cnt(word_cnt2), .seq_done(seq_done2), .seq_pass(seq_pass2));

  always #5 clk = ~clk;

  function automatic int succ(int x);
    return (x / 2) ^ ((x % 2 == 1) ? 'hB8 : 0);
  endfunction

  task automatic m_reset();
    m_mode = 0; m_pred = 0; m_run = 0; m_miss = 0; m_errs = 0; m_words = 0;
    m_seqerr = 0; m_errp = 0; m_sdone = 0; m_spass = 0;
  endtask

  task automatic model(bit v, int d, bit dn, bit c);
    m_errp = 0; m_sdone = 0;
    if (c) begin m_reset(); return; end
    if (v) begin
      if (m_words < 511) m_words++;
      if (m_mode == 0) begin
        if (d != 0) begin m_pred = succ(d); m_run = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == m_pred) begin
          m_pred = succ(m_pred); m_run++;
          if (m_run == LOCK_CNT) begin m_mode = 2; m_miss = 0; end
        end else begin
          m_run = 0; m_pred = succ(d);
          if (d == 0) m_mode = 0;
        end
      end else begin
        if (d == m_pred) m_miss = 0;
        else begin m_errp = 1; m_errs++; m_seqerr = 1; m_miss++; end
        m_pred = succ(m_pred);
        if (m_miss == UNLOCK_CNT) begin m_mode = 0; m_miss = 0; m_run = 0; end
      end
    end
    if (dn) begin
      m_sdone = 1;
      m_spass = (m_mode == 2) && !m_seqerr && (m_words == 255);
      m_words = 0; m_seqerr = 0;
    end
  endtask

  function automatic logic [43:0] exp_vec();
    int e16, e2;
    e16 = (m_errs > 65535) ? 65535 : m_errs;
    e2  = (m_errs > 3) ? 3 : m_errs;
    return {m_mode == 2, m_errp, 16'(e16), 9'(m_words), m_sdone, m_spass,
            m_mode == 2, m_errp, 2'(e2), 9'(m_words), m_sdone, m_spass};
  endfunction

  function automatic logic [43:0] dut_vec();
    return {locked, err_pulse, err_cnt, word_cnt, seq_done, seq_pass,
            locked2, err_pulse2, err_cnt2, word_cnt2, seq_done2, seq_pass2};
  endfunction

  task automatic step(bit v, int d, bit dn, bit c);
    in_vld = v; in_data = 8'(d); in_done = dn; clr = c;
    model(v, d, dn, c);
    @(posedge clk); #1;
    in_vld = 1'b0; in_done = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_vld = 1'b0; in_done = 1'b0; in_data = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec() !== 44'd0) begin
      n_bad++; $display("FAIL reset_outputs got=%h exp=0", dut_vec());
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    gen = 1;
    for (int i = 0; i < 5; i++) begin
      step(1, gen, 0, 0); gen = succ(gen);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL lock_word%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({locked, err_cnt, word_cnt} !== {1'b1, 16'd0, 9'd5}) begin
      n_bad++; $display("FAIL lock_final got=%b/%0d/%0d exp=1/0/5", locked, err_cnt, word_cnt);
    end
  endtask

  task automatic test_single_error();
    step(1, 0, 0, 0); gen = succ(gen);
    n_cmp++;
    if ({err_pulse, err_cnt, locked} !== {1'b1, 16'd1, 1'b1} || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL zero_word got=%h exp=%h", dut_vec(), exp_vec());
    end
    step(1, gen, 0, 0); gen = succ(gen);
    n_cmp++;
    if ({err_pulse, err_cnt, locked} !== {1'b0, 16'd1, 1'b1} || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL after_zero got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_unlock();
    for (int i = 0; i < 4; i++) begin
      step(1, gen ^ int'($urandom_range(1, 255)), 0, 0); gen = succ(gen);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL unlock_word%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({locked, err_cnt} !== {1'b0, 16'd5}) begin
      n_bad++; $display("FAIL unlock_final got=%b/%0d exp=0/5", locked, err_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, gen, 0, 0); gen = succ(gen);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL relock_word%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++; $display("FAIL relock_final got=%b exp=1", locked);
    end
  endtask

  task automatic test_full_period();
    int bad_idx;
    step(0, 0, 0, 1);
    for (int rep = 0; rep < 2; rep++) begin
      bad_idx = (rep == 0) ? -1 : int'($urandom_range(20, 240));
      gen = 1;
      for (int i = 0; i < 255; i++) begin
        step(1, (i == bad_idx) ? (gen ^ 1) : gen, i == 254, 0); gen = succ(gen);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_bad++; $display("FAIL period%0d_word%0d got=%h exp=%h", rep, i, dut_vec(), exp_vec());
        end
      end
      n_cmp++;
      if ({seq_done, seq_pass, word_cnt} !== {1'b1, rep == 0, 9'd0}) begin
        n_bad++; $display("FAIL period%0d_result got=%b/%b/%0d exp=1/%0d/0",
                          rep, seq_done, seq_pass, word_cnt, rep == 0);
      end
      step(0, 0, 0, 0);
      n_cmp++;
      if ({seq_done, seq_pass} !== {1'b0, rep == 0} || dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL period%0d_hold got=%h exp=%h", rep, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_gaps();
    bit v, dn;
    int d;
    step(0, 0, 0, 1);
    gen = 1;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom % 2) == 1;
      dn = (i % 97) == 96;
      d  = int'($urandom_range(0, 255));
      if (v) begin
        d = gen;
        if (i >= 200 && ($urandom % 6) == 0) d = gen ^ 'h5A;
        gen = succ(gen);
      end
      step(v, d, dn, 0);
      n_cmp++;
      if (dut_vec() !== exp_vec() || (i < 200 && err_pulse !== 1'b0)) begin
        n_bad++; $display("FAIL gaps_cycle%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    if (m_errs >= 3) begin
      n_cmp++;
      if (err_cnt2 !== 2'd3) begin
        n_bad++; $display("FAIL err_saturate got=%0d exp=3", err_cnt2);
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 1);
    gen = 1;
    for (int i = 0; i < 6; i++) begin
      step(1, (i == 5) ? (gen ^ 'h11) : gen, 0, 0); gen = succ(gen);
    end
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL prereset got=%h exp=%h", dut_vec(), exp_vec());
    end
    #3 rst = 1'b1;
    #1;
    m_reset();
    n_cmp++;
    if ({locked, err_cnt, word_cnt} !== 26'd0) begin
      n_bad++; $display("FAIL async_reset got=%b/%0d/%0d exp=0/0/0", locked, err_cnt, word_cnt);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      step(1, gen, 0, 0); gen = succ(gen);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL postreset_word%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clr_bad();
    step(1, gen ^ 'hFF, 0, 1); gen = succ(gen);
    n_cmp++;
    if ({err_pulse, locked, err_cnt} !== 18'd0 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL clr_bad got=%h exp=%h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      step(1, gen, 0, 0); gen = succ(gen);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL clr_rehunt%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_unlock();
    test_full_period();
    test_gaps();
    test_async_reset();
    test_clr_bad();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
